// File: rtl/dot_matrix_pkg.sv
// Shared constants and types for the 16x16 dot matrix row scanner.
// Imported by the scanner top and its row decoder.
package dot_matrix_pkg;
  localparam int MATRIX_ROWS = 16;
  localparam int MATRIX_COLS = 16;
  localparam int ROW_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;
endpackage

// File: rtl/row_onehot_dec.sv
// 4-to-16 one-hot row decoder with optional active-low polarity.
// Ports: i_idx row index, i_active_low invert, o_row decoded drive.
import dot_matrix_pkg::*;

module row_onehot_dec (
  input  logic [ROW_IDX_W-1:0]   i_idx,
  input  logic                   i_active_low,
  output logic [MATRIX_ROWS-1:0] o_row
);
  logic [MATRIX_ROWS-1:0] w_hot;

  always_comb begin
    w_hot        = '0;
    w_hot[i_idx] = 1'b1;
    o_row        = w_hot ^ {MATRIX_ROWS{i_active_low}};
  end
endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver: BLANK gap, then DRIVE one row with captured columns.
// Ports: clk, rst_n, enable, col_in -> row_bin, dot_row, dot_col, frame_tick.
import dot_matrix_pkg::*;

module dot_matrix_scanner #(
  parameter int BLANK_CYCLES   = 2,
  parameter int ON_CYCLES      = 4,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [MATRIX_COLS-1:0] col_in,
  output logic [ROW_IDX_W-1:0]   row_bin,
  output logic [MATRIX_ROWS-1:0] dot_row,
  output logic [MATRIX_COLS-1:0] dot_col,
  output logic                   frame_tick
);
  localparam int MAXC  = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] O_LAST = CNT_W'(ON_CYCLES - 1);

  localparam logic ROW_POL = (ROW_ACTIVE_LOW != 0);
  localparam logic COL_POL = (COL_ACTIVE_LOW != 0);

  localparam logic [MATRIX_ROWS-1:0] ROW_OFF = {MATRIX_ROWS{ROW_POL}};
  localparam logic [MATRIX_COLS-1:0] COL_OFF = {MATRIX_COLS{COL_POL}};

  scan_state_t r_state, w_nxt_state;
  logic [CNT_W-1:0]       r_cnt, w_nxt_cnt;
  logic [ROW_IDX_W-1:0]   r_row_bin, w_nxt_row;
  logic [MATRIX_ROWS-1:0] r_dot_row, w_nxt_dot_row, w_dec_row;
  logic [MATRIX_COLS-1:0] r_dot_col, w_nxt_dot_col;
  logic                   r_tick, w_nxt_tick, w_lit;

  row_onehot_dec u_dec (
    .i_idx        (r_row_bin),
    .i_active_low (ROW_POL),
    .o_row        (w_dec_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_row_bin <= '0;
      r_dot_row <= ROW_OFF;
      r_dot_col <= COL_OFF;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_row_bin <= w_nxt_row;
      r_dot_row <= w_nxt_dot_row;
      r_dot_col <= w_nxt_dot_col;
      r_tick    <= w_nxt_tick;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_nxt_row   = r_row_bin;
    if (!enable) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = '0;
      w_nxt_row   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_nxt_state = BLANK;
          w_nxt_cnt   = '0;
          w_nxt_row   = '0;
        end
        BLANK: begin
          if (r_cnt == B_LAST) begin
            w_nxt_state = DRIVE;
            w_nxt_cnt   = '0;
          end
        end
        DRIVE: begin
          if (r_cnt == O_LAST) begin
            w_nxt_state = BLANK;
            w_nxt_cnt   = '0;
            w_nxt_row   = r_row_bin + 1'b1;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
          w_nxt_row   = '0;
        end
      endcase
    end
  end

  // Outputs are registered, so they are computed from the next state.
  // The row never changes on entry to DRIVE, so r_row_bin feeds the decoder.
  always_comb begin
    w_lit         = (w_nxt_state == DRIVE);
    w_nxt_dot_row = w_lit ? w_dec_row : ROW_OFF;
    w_nxt_dot_col = COL_OFF;
    if (w_lit && r_state == BLANK)
      w_nxt_dot_col = col_in ^ COL_OFF;
    else if (w_lit)
      w_nxt_dot_col = r_dot_col;
    // Tick lands on the final lit clock of row 15.
    w_nxt_tick = w_lit && (w_nxt_cnt == O_LAST)
                 && (r_row_bin == ROW_IDX_W'(MATRIX_ROWS - 1));
  end

  assign row_bin    = r_row_bin;
  assign dot_row    = r_dot_row;
  assign dot_col    = r_dot_col;
  assign frame_tick = r_tick;
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner, default and inverted polarity.
// Both instances share clk/rst_n/enable; a ROM model supplies col_in.
module tb_dot_matrix_scanner;
  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [15:0] glitch;
  logic [15:0] col_a, col_b;
  logic [3:0]  rb_a, rb_b;
  logic [15:0] row_a, row_b, dc_a, dc_b;
  logic        ft_a, ft_b;
  int          vectors = 0;
  int          miscompares = 0;
  int          ticks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [3:0] r);
    case (r)
      4'd1:    rom = 16'h0C00;
      4'd2:    rom = 16'h1E00;
      4'd5:    rom = 16'h0780;
      default: rom = {r, 4'h9, ~r, 4'h3};
    endcase
  endfunction

  always_comb col_a = rom(rb_a) ^ glitch;
  always_comb col_b = rom(rb_b) ^ glitch;

  dot_matrix_scanner u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col_in(col_a),
    .row_bin(rb_a), .dot_row(row_a), .dot_col(dc_a), .frame_tick(ft_a)
  );

  dot_matrix_scanner #(
    .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col_in(col_b),
    .row_bin(rb_b), .dot_row(row_b), .dot_col(dc_b), .frame_tick(ft_b)
  );

  task automatic cmp(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // k=0: idle/blank-out; k>=1: k-th clock since the scan started.
  task automatic chk(input int k);
    int          row, p;
    logic        drv, tk;
    logic [15:0] er, ec;
    row = (k == 0) ? 0 : ((k - 1) / 6) % 16;
    p   = (k == 0) ? 0 : (k - 1) % 6;
    drv = (k != 0) && (p >= 2);
    tk  = drv && (p == 5) && (row == 15);
    er  = drv ? (16'h0001 << row) : 16'h0000;
    ec  = drv ? rom(4'(row)) : 16'h0000;
    if (ft_a === 1'b1) ticks++;
    cmp($sformatf("row_bin k=%0d", k), {12'h0, rb_a}, 16'(row));
    cmp($sformatf("dot_row k=%0d", k), row_a, er);
    cmp($sformatf("dot_col k=%0d", k), dc_a, ec);
    cmp($sformatf("tick k=%0d", k), {15'h0, ft_a}, {15'h0, tk});
    cmp($sformatf("inv_row_bin k=%0d", k), {12'h0, rb_b}, 16'(row));
    cmp($sformatf("inv_dot_row k=%0d", k), row_b, ~er);
    cmp($sformatf("inv_dot_col k=%0d", k), dc_b, ~ec);
    cmp($sformatf("inv_tick k=%0d", k), {15'h0, ft_b}, {15'h0, tk});
    // Scramble col_in except across the capture edge of the last blank clock.
    glitch = (k != 0 && p >= 2) ? 16'h5A5A : 16'h0000;
  endtask

  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk(k);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    glitch = 16'h0000;
    repeat (2) @(negedge clk);
    chk(0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk(0);
    end

    enable = 1'b1;
    run(238);
    cmp("tick_count_frames", 16'(ticks), 16'd2);
    cmp("row1_col", 16'(rom(4'd1)), 16'h0C00);

    enable = 1'b0;
    glitch = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk(0);
    end

    enable = 1'b1;
    run(57);
    cmp("tick_count_reenable", 16'(ticks), 16'd2);

    #2 rst_n = 1'b0;
    #1;
    cmp("async_row_bin", {12'h0, rb_a}, 16'h0000);
    cmp("async_dot_row", row_a, 16'h0000);
    cmp("async_dot_col", dc_a, 16'h0000);
    cmp("async_inv_dot_row", row_b, 16'hFFFF);
    cmp("async_inv_dot_col", dc_b, 16'hFFFF);
    cmp("async_tick", {15'h0, ft_a}, 16'h0000);
    glitch = 16'h0000;
    @(negedge clk);
    chk(0);
    rst_n = 1'b1;
    run(9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
